serial_subtractor: RTL and testbench

Sequential bit-serial subtractor that computes A − B − Bin one bit per clock through a single full-subtractor cell with a registered borrow. It is the counterpart to the ripple-carry adders in the arithmetic lab set. It trades the ripple chain for a WIDTH-cycle start/done handshake, and it feeds ALU and comparator blocks that can tolerate multi-cycle latency.

---
 rtl/serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_serial_subtractor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin through one full-subtractor cell
// with a registered borrow. WIDTH-cycle start/busy/done handshake.
// Optional feature: define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERSUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic diff_bit;
  logic borrow_nxt;
  assign diff_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
  assign borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

  // Next-state and datapath update; DONE accepts start like IDLE for back-to-back ops.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERSUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERSUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = borrow_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the finished result only on the edge entering DONE.
          d_d     = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
`ifdef SERSUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) & (diff_bit != a_msb_q);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERSUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERSUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); checks ovf when SERSUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] held_d;
  logic         held_bout;
  logic         held_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    ur = ua - ub - int'(mbin);
    sr = sa - sb - int'(mbin);
    ed = W'(ur);
    eb = (ur < 0);
    eo = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_d"}, 32'(d), 32'(held_d));
    chk({tag, "_bout"}, 32'(bout), 32'(held_bout));
`ifdef SERSUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(held_ovf));
`endif
  endtask

  // One operation; call 1 time unit after a posedge while the DUT is idle or in DONE.
  // junk=1 holds start high with different operands while busy.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       input bit junk);
    logic [W-1:0] ed;
    logic eb, eo;
    model(oa, ob, obin, ed, eb, eo);
    start = 1'b1; a = oa; b = ob; bin = obin;
    @(posedge clk); #1;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    start = junk; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int k = 1; k < int'(W); k++) begin
      @(posedge clk); #1;
      chk("shift_busy", 32'(busy), 32'd1);
      chk("shift_done", 32'(done), 32'd0);
      chk_outputs("shift_hold");
    end
    @(posedge clk); #1;
    held_d = ed; held_bout = eb; held_ovf = eo;
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd0);
    chk_outputs("fin");
    start = 1'b0;
  endtask

  // Idle cycle after a result: done must drop and outputs hold.
  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk_outputs("idle_hold");
  endtask

  initial begin
    held_d = '0; held_bout = 1'b0; held_ovf = 1'b0;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(4'h7, 4'h3, 1'b0, 1'b0); idle_cycle();
    chk("basic_d", 32'(d), 32'h4);
    do_op(4'h3, 4'h7, 1'b0, 1'b0); idle_cycle();
    chk("borrow_d", 32'(d), 32'hC);
    chk("borrow_bout", 32'(bout), 32'd1);
    do_op(4'h0, 4'h0, 1'b1, 1'b0); idle_cycle();
    chk("zero_bin_d", 32'(d), 32'hF);
    do_op(4'h8, 4'h1, 1'b0, 1'b0); idle_cycle();
    chk("ovf_case_d", 32'(d), 32'h7);
    do_op(4'h5, 4'h3, 1'b0, 1'b0); idle_cycle();
    chk("noovf_case_d", 32'(d), 32'h2);

    // start held high with other operands while busy.
    do_op(4'h9, 4'h2, 1'b1, 1'b1); idle_cycle();

    // Back-to-back: second start during the done cycle.
    do_op(4'hA, 4'h4, 1'b0, 1'b0);
    do_op(4'hF, 4'h1, 1'b0, 1'b0);
    chk("b2b_d", 32'(d), 32'hE);
    idle_cycle();

    // Reset two cycles into an operation.
    start = 1'b1; a = 4'h6; b = 4'h1; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    held_d = '0; held_bout = 1'b0; held_ovf = 1'b0;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk_outputs("arst");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < int'(W) + 2; k++) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    do_op(4'hC, 4'h5, 1'b1, 1'b0); idle_cycle();

    // Randomized operations, mixing back-to-back, junk starts and idle gaps.
    for (int n = 0; n < 60; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
